// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built from one 4-bit slice, iterated LSB nibble first.
// A start/busy/done handshake issues one operation at a time.
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 SUB,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 CARRY_IN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [4*NIBBLES-1:0] RESULT,
    output logic                 CARRY_OUT,
    output logic                 OVERFLOW
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_q, b_q, acc, acc_nxt;
    logic [IW-1:0] idx;
    logic          carry_q;
    logic [3:0]    a_nib, b_nib;
    logic [4:0]    sum5;
    logic          c3;

    // Slice datapath: the selected nibble pair plus the linking carry.
    always_comb begin
        a_nib   = a_q[idx*4 +: 4];
        b_nib   = b_q[idx*4 +: 4];
        sum5    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
        c3      = a_nib[3] ^ b_nib[3] ^ sum5[3];
        acc_nxt = acc;
        acc_nxt[idx*4 +: 4] = sum5[3:0];
    end

    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE: if (START) state_nxt = S_RUN;
            S_RUN: begin
                BUSY = 1'b1;
                if (idx == LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                BUSY      = 1'b1;
                DONE      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            idx       <= '0;
            carry_q   <= 1'b0;
            RESULT    <= '0;
            CARRY_OUT <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a_q     <= A;
                        b_q     <= SUB ? ~B : B;
                        carry_q <= SUB ? 1'b1 : CARRY_IN;
                        acc     <= '0;
                        idx     <= '0;
                    end
                end
                S_RUN: begin
                    acc     <= acc_nxt;
                    carry_q <= sum5[4];
                    // Final nibble publishes everything at once; index holds at LAST.
                    if (idx == LAST) begin
                        RESULT    <= acc_nxt;
                        CARRY_OUT <= sum5[4];
                        OVERFLOW  <= c3 ^ sum5[4];
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench: vector table for NIBBLES=4, hand sequences for
// busy-start, mid-run reset, reset/start collision and a NIBBLES=2 instance.
module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, sub, cin;
    logic [15:0] a, b;
    logic        busy, done, co, ov;
    logic [15:0] res;

    logic        rst2, start2, sub2, cin2;
    logic [7:0]  a2, b2;
    logic        busy2, done2, co2, ov2;
    logic [7:0]  res2;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .CLK(clk), .RST(rst), .START(start), .SUB(sub), .A(a), .B(b),
        .CARRY_IN(cin), .BUSY(busy), .DONE(done), .RESULT(res),
        .CARRY_OUT(co), .OVERFLOW(ov)
    );

    nibble_serial_adder_ctrl #(.NIBBLES(2)) dut2 (
        .CLK(clk), .RST(rst2), .START(start2), .SUB(sub2), .A(a2), .B(b2),
        .CARRY_IN(cin2), .BUSY(busy2), .DONE(done2), .RESULT(res2),
        .CARRY_OUT(co2), .OVERFLOW(ov2)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    // Issue one op, scramble inputs after the START edge, and check the completion.
    task automatic do_op(input string nm, input vec_t v, input logic [15:0] prev_res);
        int lat = 0;
        int busy_cnt = 0;
        a = v.a; b = v.b; sub = v.sub; cin = v.cin; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~v.a; b = ~v.b; sub = ~v.sub; cin = ~v.cin;
        if (busy) busy_cnt++;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (busy) busy_cnt++;
            if (k == 1) check({nm, ".held"}, res, prev_res);
            if (done) begin
                lat = k;
                break;
            end
        end
        check({nm, ".latency"}, lat, 4);
        check({nm, ".result"}, res, v.res);
        check({nm, ".carry"}, co, v.co);
        check({nm, ".ovf"}, ov, v.ov);
        check({nm, ".busycycles"}, busy_cnt, 5);
        tick();
        check({nm, ".donepulse"}, {busy, done}, 2'b00);
    endtask

    vec_t vecs[5];

    initial begin
        int ndone;
        logic [15:0] prev;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h0FCB, 1'b0, 1'b1, 16'h2200, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        rst2 = 1'b1; start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
        tick();
        tick();
        check("reset.outs", {busy, done, res, co, ov}, 20'h0);
        check("reset2.outs", {busy2, done2, res2, co2, ov2}, 12'h0);
        rst = 1'b0; rst2 = 1'b0;
        tick();

        prev = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i], prev);
            prev = vecs[i].res;
        end

        // START while busy must be ignored.
        a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0; a = 16'h1111; b = 16'h2222;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) ndone++;
        end
        check("ignore.donecount", ndone, 1);
        check("ignore.result", res, 16'h0002);
        check("ignore.idle", busy, 1'b0);

        // Reset two cycles into RUN aborts without a DONE pulse.
        a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.outs", {busy, done, res, co, ov}, 20'h0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done | busy) ndone++;
        end
        check("abort.nodone", ndone, 0);
        do_op("fresh", '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0}, 16'h0000);

        // Reset and START together: reset wins.
        rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        check("rststart.idle", {busy, res}, 17'h0);

        // NIBBLES=2 instance.
        a2 = 8'hF0; b2 = 8'h10; sub2 = 1'b0; cin2 = 1'b0; start2 = 1'b1;
        tick();
        start2 = 1'b0; a2 = 8'h00; b2 = 8'h00;
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (done2) begin
                ndone = k;
                break;
            end
        end
        check("n2.latency", ndone, 2);
        check("n2.result", res2, 8'h00);
        check("n2.carry", co2, 1'b1);
        check("n2.ovf", ov2, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
